// File: rtl/sd_cmd_resp_receiver.sv
// SD CMD-line response receiver for 48-bit and 136-bit (R2) frames.
// Define SD_CMD_RESP_CRC_CHECK_EN to enable the CRC7 check that drives out_crc_err.
`ifndef CMD_STATE_SEND
`define CMD_STATE_SEND 3'd1
`endif
`ifndef CMD_STATE_WAIT_RECEIVE
`define CMD_STATE_WAIT_RECEIVE 3'd2
`endif
`ifndef CMD_STATE_STOP
`define CMD_STATE_STOP 3'd3
`endif

module sd_cmd_resp_receiver (
  input  logic         in_sd_clk,
  input  logic         hrst_n,
  input  logic         in_soft_reset,
  input  logic [2:0]   in_current_state,
  input  logic         in_long_response,
  input  logic         in_sd_cmd,
  output logic [127:0] out_response,
  output logic [5:0]   out_resp_index,
  output logic         out_resp_done,
  output logic         out_resp_timeout,
  output logic         out_crc_err,
  output logic         out_end_bit_err,
  output logic         out_receiving
);

  typedef enum logic [1:0] {IDLE, WAIT_START, RECEIVE, DONE} state_e;

  state_e         state_q, state_d;
  logic [6:0]     tcnt_q, tcnt_d;
  logic [7:0]     bcnt_q, bcnt_d;
  logic [134:0]   shreg_q, shreg_d;
  logic           long_q, long_d;
  logic [127:0]   resp_q, resp_d;
  logic [5:0]     idx_q, idx_d;
  logic           enderr_q, enderr_d;
  logic           tout_q, tout_d;

  logic           abort;
  logic           start_seen;
  logic           frame_end;
  logic           unused_shreg_msb;

  assign abort      = (in_current_state == `CMD_STATE_SEND) ||
                      (in_current_state == `CMD_STATE_STOP);
  assign start_seen = (state_q == WAIT_START) && !abort && !in_sd_cmd;
  assign frame_end  = (state_q == RECEIVE) && !abort && (bcnt_q == '0);

  // The transmission bit ends up in the MSB and is never inspected.
  assign unused_shreg_msb = shreg_q[134];

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    bcnt_d   = bcnt_q;
    shreg_d  = shreg_q;
    long_d   = long_q;
    resp_d   = resp_q;
    idx_d    = idx_q;
    enderr_d = enderr_q;
    tout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_current_state == `CMD_STATE_WAIT_RECEIVE) begin
          state_d = WAIT_START;
          tcnt_d  = '0;
        end
      end
      WAIT_START: begin
        if (abort) begin
          state_d = IDLE;
        end else if (start_seen) begin
          state_d = RECEIVE;
          long_d  = in_long_response;
          bcnt_d  = in_long_response ? 8'd134 : 8'd46;
        end else if (tcnt_q == 7'd63) begin
          state_d = IDLE;
          tout_d  = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 7'd1;
        end
      end
      RECEIVE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          shreg_d = {shreg_q[133:0], in_sd_cmd};
          // Result registers load on the end-bit edge so they are valid while done is high.
          if (frame_end) begin
            state_d  = DONE;
            enderr_d = ~in_sd_cmd;
            if (long_q) begin
              resp_d = shreg_d[127:0];
              idx_d  = 6'h3F;
            end else begin
              resp_d = {96'b0, shreg_d[39:8]};
              idx_d  = shreg_d[45:40];
            end
          end else begin
            bcnt_d = bcnt_q - 8'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_sd_clk or negedge hrst_n) begin
    if (!hrst_n) begin
      state_q  <= IDLE;
      tcnt_q   <= '0;
      bcnt_q   <= '0;
      shreg_q  <= '0;
      long_q   <= 1'b0;
      resp_q   <= '0;
      idx_q    <= '0;
      enderr_q <= 1'b0;
      tout_q   <= 1'b0;
    end else if (!in_soft_reset) begin
      state_q  <= IDLE;
      tcnt_q   <= '0;
      bcnt_q   <= '0;
      shreg_q  <= '0;
      long_q   <= 1'b0;
      resp_q   <= '0;
      idx_q    <= '0;
      enderr_q <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      bcnt_q   <= bcnt_d;
      shreg_q  <= shreg_d;
      long_q   <= long_d;
      resp_q   <= resp_d;
      idx_q    <= idx_d;
      enderr_q <= enderr_d;
      tout_q   <= tout_d;
    end
  end

`ifdef SD_CMD_RESP_CRC_CHECK_EN
  logic [6:0] crc_q, crc_d;
  logic       crcerr_q, crcerr_d;
  logic       crc_fb;
  logic       crc_window;

  // Short frames cover bits 46..8 (the zero start bit leaves a zero seed unchanged);
  // long frames cover only the content bits 127..8.
  assign crc_window = (bcnt_q >= 8'd8) && (!long_q || (bcnt_q <= 8'd127));
  assign crc_fb     = crc_q[6] ^ in_sd_cmd;

  always_comb begin
    crc_d    = crc_q;
    crcerr_d = crcerr_q;
    if (start_seen) begin
      crc_d = '0;
    end else if ((state_q == RECEIVE) && !abort && crc_window) begin
      crc_d = {crc_q[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);
    end
    if (frame_end) crcerr_d = (crc_q != shreg_d[7:1]);
  end

  always_ff @(posedge in_sd_clk or negedge hrst_n) begin
    if (!hrst_n) begin
      crc_q    <= '0;
      crcerr_q <= 1'b0;
    end else if (!in_soft_reset) begin
      crc_q    <= '0;
      crcerr_q <= 1'b0;
    end else begin
      crc_q    <= crc_d;
      crcerr_q <= crcerr_d;
    end
  end

  assign out_crc_err = crcerr_q;
`else
  assign out_crc_err = 1'b0;
`endif

  assign out_response     = resp_q;
  assign out_resp_index   = idx_q;
  assign out_end_bit_err  = enderr_q;
  assign out_resp_timeout = tout_q;
  assign out_resp_done    = (state_q == DONE);
  assign out_receiving    = (state_q == RECEIVE);

endmodule
